cache_mem_port_arbiter: RTL and testbench

- Shares one internal memory-controller command/buffer port between two cache instances: port 0 = instruction cache, port 1 = data cache.
- Round-robin arbitration at transaction granularity. A grant is held until the full single-word or block transfer completes.
- Sits between the caches' req/rw/add/write/read/data buffer ports and the memory controller buffer.

---
 rtl/cache_mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_cache_mem_port_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cache_mem_port_arbiter.sv
// rtl/cache_mem_port_arbiter.sv - two-port transaction-level arbiter onto one memory-controller buffer port
module cache_mem_port_arbiter #(
    parameter int BW_ADDR    = 10,
    parameter int BW_BLK     = 2,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                   clock_i,
    input  logic                   resetn_i,
    input  logic [1:0]             req_i,
    input  logic [1:0]             req_block_i,
    input  logic [1:0]             rw_i,
    input  logic [2*BW_ADDR-1:0]   add_i,
    input  logic [1:0]             write_i,
    input  logic [1:0]             read_i,
    input  logic [63:0]            wdata_i,
    output logic [1:0]             en_o,
    output logic [1:0]             ready_req_o,
    output logic [1:0]             ready_write_o,
    output logic [1:0]             ready_read_o,
    output logic [31:0]            rdata_o,
    input  logic                   mem_ready_req_i,
    input  logic                   mem_ready_write_i,
    input  logic                   mem_ready_read_i,
    input  logic [31:0]            mem_rdata_i,
    output logic                   mem_req_o,
    output logic                   mem_req_block_o,
    output logic                   mem_rw_o,
    output logic [BW_ADDR-1:0]     mem_add_o,
    output logic                   mem_write_o,
    output logic                   mem_read_o,
    output logic [31:0]            mem_wdata_o,
    output logic [1:0]             grant_o,
    output logic                   busy_o
);
    typedef enum logic [1:0] {IDLE, CMD, XFER, DONE} state_t;

    localparam logic [BW_BLK:0] ONE_BEAT  = {{BW_BLK{1'b0}}, 1'b1};
    localparam logic [BW_BLK:0] BLK_BEATS = {1'b1, {BW_BLK{1'b0}}};

    state_t             state;
    logic               gnt_idx;
    logic               last;
    logic               lat_block;
    logic               lat_rw;
    logic [BW_ADDR-1:0] lat_add;
    logic [BW_BLK:0]    count;
    logic [BW_BLK:0]    len;
    logic               win_idx;
    logic               beat;

    // On a tie the round-robin winner is whichever port did not own the last transaction
    always_comb begin
        win_idx = req_i[1];
        if (req_i == 2'b11) begin
            win_idx = FIXED_PRIO ? 1'b0 : ~last;
        end
    end

    always_comb begin
        beat = 1'b0;
        if (state == XFER) begin
            beat = lat_rw ? (write_i[gnt_idx] & mem_ready_write_i)
                          : (read_i[gnt_idx] & mem_ready_read_i);
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt_idx   <= 1'b0;
            lat_block <= 1'b0;
            lat_rw    <= 1'b0;
            lat_add   <= '0;
            count     <= '0;
            len       <= '0;
            grant_o   <= 2'b00;
            busy_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        gnt_idx   <= win_idx;
                        lat_block <= req_block_i[win_idx];
                        lat_rw    <= rw_i[win_idx];
                        lat_add   <= win_idx ? add_i[2*BW_ADDR-1 -: BW_ADDR] : add_i[BW_ADDR-1:0];
                        grant_o   <= win_idx ? 2'b10 : 2'b01;
                        busy_o    <= 1'b1;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    if (mem_ready_req_i) begin
                        count <= '0;
                        len   <= lat_block ? BLK_BEATS : ONE_BEAT;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        count <= count + ONE_BEAT;
                        if (count == len - ONE_BEAT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    last    <= gnt_idx;
                    grant_o <= 2'b00;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The non-owning port sees no ready and its strobes never reach the controller
    always_comb begin
        en_o            = 2'b11;
        ready_req_o     = 2'b00;
        ready_write_o   = 2'b00;
        ready_read_o    = 2'b00;
        mem_req_o       = 1'b0;
        mem_req_block_o = 1'b0;
        mem_rw_o        = 1'b0;
        mem_add_o       = '0;
        mem_write_o     = 1'b0;
        mem_read_o      = 1'b0;
        mem_wdata_o     = '0;
        if (state != IDLE) begin
            en_o = gnt_idx ? 2'b10 : 2'b01;
        end
        case (state)
            CMD: begin
                mem_req_o            = 1'b1;
                mem_req_block_o      = lat_block;
                mem_rw_o             = lat_rw;
                mem_add_o            = lat_add;
                ready_req_o[gnt_idx] = mem_ready_req_i;
            end
            XFER: begin
                if (lat_rw) begin
                    mem_write_o            = write_i[gnt_idx];
                    mem_wdata_o            = gnt_idx ? wdata_i[63:32] : wdata_i[31:0];
                    ready_write_o[gnt_idx] = mem_ready_write_i;
                end else begin
                    mem_read_o            = read_i[gnt_idx];
                    ready_read_o[gnt_idx] = mem_ready_read_i;
                end
            end
            default: ;
        endcase
    end

    assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_cache_mem_port_arbiter.sv
// tb/tb_cache_mem_port_arbiter.sv - randomized bench for round-robin and fixed-priority arbiter instances
module tb_cache_mem_port_arbiter;
    localparam int BW_ADDR = 10;
    localparam int BW_BLK  = 2;
    localparam int NBEAT   = 1 << BW_BLK;

    logic                 clock_i = 1'b0;
    logic                 resetn_i;
    logic [1:0]           req_i, req_block_i, rw_i, write_i, read_i;
    logic [2*BW_ADDR-1:0] add_i;
    logic [63:0]          wdata_i;
    logic                 mem_ready_req_i, mem_ready_write_i, mem_ready_read_i;
    logic [31:0]          mem_rdata_i;

    logic [1:0]         en_rr, rreq_rr, rwr_rr, rrd_rr, grant_rr;
    logic [31:0]        rdata_rr, wdata_rr;
    logic               mreq_rr, mblk_rr, mrw_rr, mwr_rr, mrd_rr, busy_rr;
    logic [BW_ADDR-1:0] madd_rr;
    logic [1:0]         en_fp, rreq_fp, rwr_fp, rrd_fp, grant_fp;
    logic [31:0]        rdata_fp, wdata_fp;
    logic               mreq_fp, mblk_fp, mrw_fp, mwr_fp, mrd_fp, busy_fp;
    logic [BW_ADDR-1:0] madd_fp;

    always #5 clock_i = ~clock_i;

    cache_mem_port_arbiter #(.BW_ADDR(BW_ADDR), .BW_BLK(BW_BLK), .FIXED_PRIO(1'b0)) u_rr (
        .clock_i(clock_i), .resetn_i(resetn_i), .req_i(req_i), .req_block_i(req_block_i),
        .rw_i(rw_i), .add_i(add_i), .write_i(write_i), .read_i(read_i), .wdata_i(wdata_i),
        .en_o(en_rr), .ready_req_o(rreq_rr), .ready_write_o(rwr_rr), .ready_read_o(rrd_rr),
        .rdata_o(rdata_rr), .mem_ready_req_i(mem_ready_req_i), .mem_ready_write_i(mem_ready_write_i),
        .mem_ready_read_i(mem_ready_read_i), .mem_rdata_i(mem_rdata_i), .mem_req_o(mreq_rr),
        .mem_req_block_o(mblk_rr), .mem_rw_o(mrw_rr), .mem_add_o(madd_rr), .mem_write_o(mwr_rr),
        .mem_read_o(mrd_rr), .mem_wdata_o(wdata_rr), .grant_o(grant_rr), .busy_o(busy_rr)
    );

    cache_mem_port_arbiter #(.BW_ADDR(BW_ADDR), .BW_BLK(BW_BLK), .FIXED_PRIO(1'b1)) u_fp (
        .clock_i(clock_i), .resetn_i(resetn_i), .req_i(req_i), .req_block_i(req_block_i),
        .rw_i(rw_i), .add_i(add_i), .write_i(write_i), .read_i(read_i), .wdata_i(wdata_i),
        .en_o(en_fp), .ready_req_o(rreq_fp), .ready_write_o(rwr_fp), .ready_read_o(rrd_fp),
        .rdata_o(rdata_fp), .mem_ready_req_i(mem_ready_req_i), .mem_ready_write_i(mem_ready_write_i),
        .mem_ready_read_i(mem_ready_read_i), .mem_rdata_i(mem_rdata_i), .mem_req_o(mreq_fp),
        .mem_req_block_o(mblk_fp), .mem_rw_o(mrw_fp), .mem_add_o(madd_fp), .mem_write_o(mwr_fp),
        .mem_read_o(mrd_fp), .mem_wdata_o(wdata_fp), .grant_o(grant_fp), .busy_o(busy_fp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: owner (-1 = none), command pending, beats remaining, one-cycle wrap-up
    int                 owner[2];
    int                 beats_left[2];
    int                 last_w[2];
    logic               cmd_wait[2];
    logic               wrap_up[2];
    logic               lblk[2];
    logic               lrw[2];
    logic [BW_ADDR-1:0] ladd[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; beats_left[k] = 0; last_w[k] = 1;
            cmd_wait[k] = 1'b0; wrap_up[k] = 1'b0;
            lblk[k] = 1'b0; lrw[k] = 1'b0; ladd[k] = '0;
        end
    endtask

    function automatic logic moving(input int k);
        return owner[k] >= 0 && !cmd_wait[k] && !wrap_up[k];
    endfunction

    function automatic logic beat_of(input int k);
        if (!moving(k)) return 1'b0;
        return lrw[k] ? (write_i[owner[k]] & mem_ready_write_i) : (read_i[owner[k]] & mem_ready_read_i);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (owner[k] < 0) begin
                if (req_i != 2'b00) begin
                    int w;
                    if (req_i == 2'b11) w = (k == 1) ? 0 : 1 - last_w[k];
                    else w = req_i[1] ? 1 : 0;
                    owner[k] = w; cmd_wait[k] = 1'b1;
                    lblk[k] = req_block_i[w]; lrw[k] = rw_i[w];
                    ladd[k] = (w == 1) ? add_i[2*BW_ADDR-1:BW_ADDR] : add_i[BW_ADDR-1:0];
                end
            end else if (cmd_wait[k]) begin
                if (mem_ready_req_i) begin
                    cmd_wait[k] = 1'b0;
                    beats_left[k] = lblk[k] ? NBEAT : 1;
                end
            end else if (wrap_up[k]) begin
                last_w[k] = owner[k]; owner[k] = -1; wrap_up[k] = 1'b0;
            end else if (beat_of(k)) begin
                beats_left[k]--;
                if (beats_left[k] == 0) wrap_up[k] = 1'b1;
            end
        end
    endtask

    task automatic expect_for(input int k, output logic [63:0] ctl, output logic [63:0] cmd,
                              output logic [63:0] bv);
        logic [1:0] gr, en, rq, rwy, rry;
        logic       mw, mr;
        logic [31:0] wd;
        gr = 2'b00; rq = 2'b00; rwy = 2'b00; rry = 2'b00; mw = 1'b0; mr = 1'b0; wd = '0;
        if (owner[k] >= 0) gr[owner[k]] = 1'b1;
        en = (owner[k] < 0) ? 2'b11 : gr;
        if (owner[k] >= 0 && cmd_wait[k]) rq[owner[k]] = mem_ready_req_i;
        if (moving(k)) begin
            if (lrw[k]) begin
                rwy[owner[k]] = mem_ready_write_i;
                mw = write_i[owner[k]];
                wd = (owner[k] == 1) ? wdata_i[63:32] : wdata_i[31:0];
            end else begin
                rry[owner[k]] = mem_ready_read_i;
                mr = read_i[owner[k]];
            end
        end
        ctl = 64'({en, rq, rwy, rry, gr, owner[k] >= 0});
        cmd = (owner[k] >= 0 && cmd_wait[k]) ? 64'({1'b1, lblk[k], lrw[k], ladd[k]}) : 64'(0);
        bv  = 64'({mw, mr, mw ? wd : 32'h0});
    endtask

    initial begin
        logic [63:0] e_ctl, e_cmd, e_bv;
        req_i = '0; req_block_i = '0; rw_i = '0; add_i = '0; write_i = '0; read_i = '0;
        wdata_i = '0; mem_ready_req_i = 1'b0; mem_ready_write_i = 1'b0; mem_ready_read_i = 1'b0;
        mem_rdata_i = '0; resetn_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clock_i);
        check("reset rr en/grant/busy", 64'({en_rr, grant_rr, busy_rr}), 64'({2'b11, 2'b00, 1'b0}));
        check("reset fp en/grant/busy", 64'({en_fp, grant_fp, busy_fp}), 64'({2'b11, 2'b00, 1'b0}));
        resetn_i = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock_i);
            req_i             = (cyc < 300) ? 2'b11 : 2'($urandom_range(0, 3));
            req_block_i       = 2'($urandom_range(0, 3));
            rw_i              = 2'($urandom_range(0, 3));
            add_i             = 20'($urandom);
            write_i           = 2'($urandom_range(0, 3));
            read_i            = 2'($urandom_range(0, 3));
            wdata_i           = {$urandom, $urandom};
            mem_ready_req_i   = 1'($urandom_range(0, 1));
            mem_ready_write_i = 1'($urandom_range(0, 1));
            mem_ready_read_i  = 1'($urandom_range(0, 1));
            mem_rdata_i       = $urandom;
            resetn_i          = (cyc >= 300 && $urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            if (!resetn_i) model_reset();
            #1;
            expect_for(0, e_ctl, e_cmd, e_bv);
            check($sformatf("rr ctl cyc%0d", cyc), 64'({en_rr, rreq_rr, rwr_rr, rrd_rr, grant_rr, busy_rr}), e_ctl);
            check($sformatf("rr cmd cyc%0d", cyc),
                  mreq_rr ? 64'({1'b1, mblk_rr, mrw_rr, madd_rr}) : 64'(0), e_cmd);
            check($sformatf("rr buf cyc%0d", cyc), 64'({mwr_rr, mrd_rr, mwr_rr ? wdata_rr : 32'h0}), e_bv);
            expect_for(1, e_ctl, e_cmd, e_bv);
            check($sformatf("fp ctl cyc%0d", cyc), 64'({en_fp, rreq_fp, rwr_fp, rrd_fp, grant_fp, busy_fp}), e_ctl);
            check($sformatf("fp cmd cyc%0d", cyc),
                  mreq_fp ? 64'({1'b1, mblk_fp, mrw_fp, madd_fp}) : 64'(0), e_cmd);
            check($sformatf("fp buf cyc%0d", cyc), 64'({mwr_fp, mrd_fp, mwr_fp ? wdata_fp : 32'h0}), e_bv);
            check($sformatf("rdata cyc%0d", cyc), 64'({rdata_rr, rdata_fp}), 64'({mem_rdata_i, mem_rdata_i}));
            if (resetn_i) model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
